// File: rtl/complex_mult_pkg.sv
// Shared constants and helpers for the streaming complex multiplier.
package complex_mult_pkg;

  localparam int LATENCY = 6;
  localparam int RANGE_W = 128;

  function automatic int fw(input int a, input int b);
    return a + b + 1;
  endfunction

  // True when v lies outside the signed range of a w-bit word.
  function automatic logic out_of_range(input logic signed [RANGE_W-1:0] v, input int w);
    logic signed [RANGE_W-1:0] hi;
    logic signed [RANGE_W-1:0] lo;
    hi = (RANGE_W'(1) <<< (w - 1)) - RANGE_W'(1);
    lo = -hi - RANGE_W'(1);
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/cmplx_round_sat.sv
// Output scaling for one product component: round and shift, then clamp or wrap
// to the output width, with an out-of-range flag.
module cmplx_round_sat
  import complex_mult_pkg::*;
#(
  parameter int IN_WIDTH  = 34,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 1,
  parameter int SAT       = 1,
  parameter int OUT_WIDTH = 33
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        ovf
);

  // One guard bit above the input absorbs the rounding increment.
  localparam int EW = IN_WIDTH + 1;
  localparam int SW = EW - SHIFT;
  localparam logic signed [EW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (EW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic signed [SW-1:0] round_shift(input logic signed [IN_WIDTH-1:0] v);
    logic signed [EW-1:0] t;
    t = EW'(v) + RND;
    return SW'(t >>> SHIFT);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] fit(input logic signed [SW-1:0] v);
    logic signed [RANGE_W-1:0] x;
    x = RANGE_W'(v);
    if (SAT != 0 && out_of_range(x, OUT_WIDTH))
      return v[SW-1] ? OMIN : OMAX;
    return OUT_WIDTH'(x);
  endfunction

  logic signed [SW-1:0] sc_p5;

  // stage 5: round and shift
  always_ff @(posedge clk) begin
    if (ce) sc_p5 <= round_shift(din);
  end

  // stage 6: range fit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      ovf  <= 1'b0;
    end else if (ce) begin
      dout <= fit(sc_p5);
      ovf  <= out_of_range(RANGE_W'(sc_p5), OUT_WIDTH);
    end
  end

endmodule

// File: rtl/complex_mult_stream.sv
// Pipelined complex multiplier p = a*b or a*conj(b) using three shared-term
// multipliers, with scaling, saturation and valid/ready flow control.
module complex_mult_stream
  import complex_mult_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 33,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 1,
  parameter int SAT       = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [A_WIDTH-1:0]   s_ar,
  input  logic signed [A_WIDTH-1:0]   s_ai,
  input  logic signed [B_WIDTH-1:0]   s_br,
  input  logic signed [B_WIDTH-1:0]   s_bi,
  input  logic                        s_conj,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_WIDTH-1:0] m_pr,
  output logic signed [OUT_WIDTH-1:0] m_pi,
  output logic                        m_ovf
);

  localparam int FW = fw(A_WIDTH, B_WIDTH);
  localparam int PW = FW + 1;

  logic ce;
  logic vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;

  logic signed [A_WIDTH-1:0] ar_p1, ai_p1, ar_p2, ai_p2;
  logic signed [B_WIDTH-1:0] br_p1;
  logic signed [B_WIDTH:0]   bi_ext, bip_p1, bip_p2;
  logic signed [A_WIDTH:0]   c_p2;
  logic signed [B_WIDTH+1:0] dr_p2, di_p2;
  logic signed [PW-1:0]      m0_p3, mr_p3, mi_p3;
  logic signed [PW-1:0]      pr_p4, pi_p4;
  logic                      ovf_r, ovf_i;

  // The whole pipe moves as one; a full output slot that is not taken stalls it.
  assign ce      = ~m_valid | m_ready;
  assign s_ready = ce;
  assign bi_ext  = (B_WIDTH+1)'(s_bi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      vld_p4  <= 1'b0;
      vld_p5  <= 1'b0;
      m_valid <= 1'b0;
    end else if (ce) begin
      vld_p1  <= s_valid;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      vld_p4  <= vld_p3;
      vld_p5  <= vld_p4;
      m_valid <= vld_p5;
    end
  end

  // stage 1: input register, conjugate folded into bi
  always_ff @(posedge clk) begin
    if (ce) begin
      ar_p1  <= s_ar;
      ai_p1  <= s_ai;
      br_p1  <= s_br;
      bip_p1 <= s_conj ? -bi_ext : bi_ext;
    end
  end

  // stage 2: pre-adds
  always_ff @(posedge clk) begin
    if (ce) begin
      ar_p2  <= ar_p1;
      ai_p2  <= ai_p1;
      bip_p2 <= bip_p1;
      c_p2   <= (A_WIDTH+1)'(ar_p1) - (A_WIDTH+1)'(ai_p1);
      dr_p2  <= (B_WIDTH+2)'(br_p1) - (B_WIDTH+2)'(bip_p1);
      di_p2  <= (B_WIDTH+2)'(br_p1) + (B_WIDTH+2)'(bip_p1);
    end
  end

  // stage 3: the three products
  always_ff @(posedge clk) begin
    if (ce) begin
      m0_p3 <= PW'(c_p2) * PW'(bip_p2);
      mr_p3 <= PW'(dr_p2) * PW'(ar_p2);
      mi_p3 <= PW'(di_p2) * PW'(ai_p2);
    end
  end

  // stage 4: recombine around the shared term
  always_ff @(posedge clk) begin
    if (ce) begin
      pr_p4 <= mr_p3 + m0_p3;
      pi_p4 <= mi_p3 + m0_p3;
    end
  end

  cmplx_round_sat #(
    .IN_WIDTH (PW),
    .SHIFT    (SHIFT),
    .ROUND    (ROUND),
    .SAT      (SAT),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_rs_re (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .din  (pr_p4),
    .dout (m_pr),
    .ovf  (ovf_r)
  );

  cmplx_round_sat #(
    .IN_WIDTH (PW),
    .SHIFT    (SHIFT),
    .ROUND    (ROUND),
    .SAT      (SAT),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_rs_im (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .din  (pi_p4),
    .dout (m_pi),
    .ovf  (ovf_i)
  );

  assign m_ovf = ovf_r | ovf_i;

endmodule
